// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus write
// encodings, register offsets, STATUS bit positions and the TX FSM states.
package uart_tx_pkg;

   // write_enable encodings used on the core's data-memory port
   localparam logic [2:0] WE_NONE = 3'b000;
   localparam logic [2:0] WE_BYTE = 3'b100;
   localparam logic [2:0] WE_HALF = 3'b010;
   localparam logic [2:0] WE_WORD = 3'b001;

   // register offsets, addr[3:2]
   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_DIVISOR = 2'd2;
   localparam logic [1:0] OFF_RSVD    = 2'd3;

   // STATUS bit positions
   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

   // Only the three legal encodings count as a store; anything else is ignored.
   function automatic logic we_valid(input logic [2:0] we);
      return (we != WE_NONE) && ((we == WE_BYTE) || (we == WE_HALF) || (we == WE_WORD));
   endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with power-of-two depth. The read data is the head entry,
// visible combinationally so a pop can consume it in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is still accepted when a pop frees a slot that cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage write.
   // NOTE: the data array has no reset; pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
   // NOTE: non-blocking assignments keep every register updating from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register decode, byte FIFO and an 8N1 serial
// FSM. Reads are combinational from addr; writes land on the clock edge.
module mmio_uart_tx
   import uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int          DEPTH       = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  write_enable,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        tx,
   output logic        busy
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic            hit;
   logic            wr;
   logic [1:0]      off;
   logic            fifo_push;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [7:0]      fifo_rd_data;
   logic            start_frame;
   logic            overflow;
   logic            overflow_set;
   logic            overflow_clr;
   logic [15:0]     divisor;
   tx_state_t       state;
   logic [7:0]      shift_reg;
   logic [2:0]      bit_cnt;
   logic [15:0]     period_cnt;
   logic [15:0]     frame_div;
   logic            unused_bits;

   // Byte-lane selects within a word and upper store bytes play no part here.
   assign unused_bits = ^{addr[1:0], data_in[31:16]};

   assign hit = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr  = hit && we_valid(write_enable);
   assign off = addr[3:2];

   assign fifo_push = wr && (off == OFF_TXDATA);

   // The FSM pops when idle, or at the last stop-bit cycle for back-to-back frames.
   assign start_frame = !fifo_empty &&
                        ((state == S_IDLE) || ((state == S_STOP) && (period_cnt == '0)));

   // A push to a full FIFO is dropped unless the FSM frees a slot the same cycle.
   assign overflow_set = fifo_push && fifo_full && !start_frame;
   assign overflow_clr = wr && (off == OFF_STATUS) && data_in[ST_OVF];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (start_frame),
      .wr_data (data_in[7:0]),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Sticky overflow flag; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               overflow <= 1'b0;
      else if (overflow_set) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

   // Bit-period divisor register; byte stores touch only the low byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divisor <= DEFAULT_DIV;
      end else if (wr && (off == OFF_DIVISOR)) begin
         if (write_enable == WE_BYTE) divisor[7:0] <= data_in[7:0];
         else                         divisor      <= data_in[15:0];
      end
   end

   // Zero-latency read mux.
   // NOTE: data_out gets a full default first so no path through the case infers a latch.
   always_comb begin
      data_out = '0;
      if (hit) begin
         case (off)
            OFF_STATUS: begin
               data_out[ST_BUSY]             = busy;
               data_out[ST_FULL]             = fifo_full;
               data_out[ST_EMPTY]            = fifo_empty;
               data_out[ST_OVF]              = overflow;
               data_out[ST_CNT_LSB +: CW]    = fifo_count;
            end
            OFF_DIVISOR: data_out[15:0] = divisor;
            OFF_TXDATA,
            OFF_RSVD:    data_out = '0;
            default:     data_out = '0;
         endcase
      end
   end

   // Serial FSM: each phase lasts frame_div+1 clocks; tx and busy are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         period_cnt <= '0;
         frame_div  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_frame) begin
                  state      <= S_START;
                  tx         <= 1'b0;
                  busy       <= 1'b1;
                  shift_reg  <= fifo_rd_data;
                  period_cnt <= divisor;
                  frame_div  <= divisor;
               end
            end
            S_START: begin
               if (period_cnt == '0) begin
                  state      <= S_DATA;
                  tx         <= shift_reg[0];
                  shift_reg  <= shift_reg >> 1;
                  bit_cnt    <= '0;
                  period_cnt <= frame_div;
               end else begin
                  period_cnt <= period_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (period_cnt == '0) begin
                  period_cnt <= frame_div;
                  if (bit_cnt == 3'd7) begin
                     state <= S_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     tx        <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  period_cnt <= period_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (period_cnt == '0) begin
                  if (start_frame) begin
                     state      <= S_START;
                     tx         <= 1'b0;
                     shift_reg  <= fifo_rd_data;
                     period_cnt <= divisor;
                     frame_div  <= divisor;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  period_cnt <= period_cnt - 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-level model (byte queue plus
// position within the current 10-bit frame) is compared against tx, busy and
// data_out every cycle, alongside hand-computed literal checks.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  write_enable;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        tx;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .DEPTH       (DEPTH),
      .DEFAULT_DIV (16'd103)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (write_enable),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_out),
      .tx           (tx),
      .busy         (busy)
   );

   // ---------------- behavioural model ----------------
   logic [7:0]  m_q[$];
   logic        m_ovf;
   logic [15:0] m_div;
   bit          m_busy;
   int          m_pos;
   int          m_fdiv;
   logic [7:0]  m_fbyte;
   bit          chk_en = 0;
   int          busy_cycles = 0;

   task automatic model_reset();
      m_q.delete();
      m_ovf   = 1'b0;
      m_div   = 16'd103;
      m_busy  = 0;
      m_pos   = 0;
      m_fdiv  = 0;
      m_fbyte = 8'h00;
   endtask

   task automatic model_start();
      m_fbyte = m_q.pop_front();
      m_fdiv  = int'(m_div);
      m_pos   = 0;
      m_busy  = 1;
   endtask

   // One clock edge: advance the frame, start the next one from the queue as it
   // stood before this edge, then apply any store.
   task automatic model_step();
      int pre;
      bit popped;
      pre    = m_q.size();
      popped = 0;
      if (m_busy) begin
         m_pos++;
         if (m_pos == 10 * (m_fdiv + 1)) begin
            if (pre > 0) begin
               model_start();
               popped = 1;
            end else begin
               m_busy = 0;
               m_pos  = 0;
            end
         end
      end else if (pre > 0) begin
         model_start();
         popped = 1;
      end
      if ((write_enable == 3'b100 || write_enable == 3'b010 || write_enable == 3'b001) &&
          addr[31:4] == BASE[31:4]) begin
         case (addr[3:2])
            2'd0: begin
               if (pre == DEPTH && !popped) m_ovf = 1'b1;
               else                         m_q.push_back(data_in[7:0]);
            end
            2'd1: if (data_in[3]) m_ovf = 1'b0;
            2'd2: begin
               if (write_enable == 3'b100) m_div[7:0] = data_in[7:0];
               else                        m_div      = data_in[15:0];
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic m_tx();
      int idx;
      if (!m_busy) return 1'b1;
      idx = m_pos / (m_fdiv + 1);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_fbyte[idx-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (a[31:4] == BASE[31:4]) begin
         case (a[3:2])
            2'd1: begin
               r[0]    = m_busy;
               r[1]    = (m_q.size() == DEPTH);
               r[2]    = (m_q.size() == 0);
               r[3]    = m_ovf;
               r[12:8] = 5'(m_q.size());
            end
            2'd2:    r = {16'h0000, m_div};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on every rising edge outside reset.
   initial forever begin
      @(posedge clk);
      if (!rst) model_step();
   end

   // Compare process: outputs are stable at the falling edge.
   initial forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      if (chk_en) begin
         check("cyc_tx", {31'b0, tx}, {31'b0, m_tx()});
         check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
         check("cyc_data_out", data_out, m_read(addr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [2:0] we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      #1;
      write_enable = we;
      addr         = a;
      data_in      = d;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      drive(3'b000, a, 32'h0);
      @(negedge clk);
      check(name, data_out, exp);
   endtask

   task automatic drain(input string name, input int budget);
      bit done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && !m_busy && m_q.size() == 0) begin
            done = 1;
            break;
         end
      end
      check(name, {31'b0, done}, 32'd1);
   endtask

   logic [9:0] a5_line = 10'b1101001010;  // index 0 = start bit, 9 = stop bit

   initial begin
      int bc0;
      rst          = 1'b1;
      write_enable = 3'b000;
      addr         = 32'h0;
      data_in      = 32'h0;
      model_reset();
      chk_en = 1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rd(BASE + 32'h4, 32'h0000_0004, "rst_status");
      rd(BASE + 32'h8, 32'h0000_0067, "rst_divisor");

      // single 0xA5 frame at DIV=3
      drive(3'b001, BASE + 32'h8, 32'h3);
      drive(3'b001, BASE, 32'hA5);
      for (int k = 0; k < 42; k++) begin
         @(negedge clk);
         if (k == 0 || k == 41) begin
            check("a5_idle_tx", {31'b0, tx}, 32'd1);
            check("a5_idle_busy", {31'b0, busy}, 32'd0);
         end else begin
            check("a5_tx", {31'b0, tx}, {31'b0, a5_line[(k-1)/4]});
            check("a5_busy", {31'b0, busy}, 32'd1);
         end
         if (k == 0) #1 write_enable = 3'b000;
      end
      rd(BASE + 32'h4, 32'h0000_0004, "a5_status_after");

      // ten back-to-back stores: one popped, eight queued, one overflows
      bc0 = busy_cycles;
      for (int i = 0; i < 10; i++) drive(3'b001, BASE, 32'h30 + 32'(i));
      rd(BASE + 32'h4, 32'h0000_080B, "burst_status_ovf");
      drive(3'b001, BASE + 32'h4, 32'h8);
      rd(BASE + 32'h4, 32'h0000_0803, "burst_status_clr");
      drain("burst_drain", 1000);
      check("burst_busy_total", 32'(busy_cycles - bc0), 32'd360);

      // divisor write widths
      drive(3'b001, BASE + 32'h8, 32'h67);
      drive(3'b100, BASE + 32'h8, 32'h1234_5678);
      rd(BASE + 32'h8, 32'h0000_0078, "div_byte");
      drive(3'b010, BASE + 32'h8, 32'hDEAD_BEEF);
      rd(BASE + 32'h8, 32'h0000_BEEF, "div_half");

      // reset in the middle of the data bits
      drive(3'b001, BASE + 32'h8, 32'h3);
      drive(3'b001, BASE, 32'h3C);
      drive(3'b000, BASE + 32'h4, 32'h0);
      repeat (12) @(negedge clk);
      check("pre_rst_busy", {31'b0, busy}, 32'd1);
      #1 rst = 1'b1;
      model_reset();
      #1;
      check("mid_rst_tx", {31'b0, tx}, 32'd1);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      rd(BASE + 32'h4, 32'h0000_0004, "post_rst_status");
      rd(BASE + 32'h8, 32'h0000_0067, "post_rst_div");

      // reserved offset and out-of-window accesses
      rd(BASE + 32'hC, 32'h0, "rsvd_read");
      rd(BASE + 32'h10, 32'h0, "outside_read");
      drive(3'b001, BASE + 32'h10, 32'hFFFF_FFFF);
      drive(3'b000, BASE + 32'h4, 32'h0);
      repeat (30) @(negedge clk);
      check("outside_no_frame", {31'b0, busy}, 32'd0);
      rd(BASE + 32'h4, 32'h0000_0004, "outside_status");
      rd(BASE + 32'h8, 32'h0000_0067, "outside_div");

      // randomized traffic over the window and beyond, short divisors
      drive(3'b001, BASE + 32'h8, 32'h2);
      for (int i = 0; i < 2500; i++) begin
         int          sel;
         logic [2:0]  we;
         logic [31:0] a;
         logic [31:0] d;
         sel = $urandom_range(0, 4);
         we  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         if (sel == 4) a = BASE + 32'h10 + 32'($urandom_range(0, 15));
         else          a = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
         d = $urandom;
         if (sel == 2) d = 32'($urandom_range(0, 4));
         drive(we, a, d);
      end
      drive(3'b000, BASE + 32'h4, 32'h0);
      drain("random_drain", 2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
